// File: rtl/image_dma_pkg.sv
// -----------------------------------------------------------------------------
// image_dma_pkg
// Shared types for the image block-copy engine.
//   ADDR_W / DATA_W : word-address and data width of the two-bank image memory
//   addr_t / data_t : address and data word types
//   dma_state_t     : transfer FSM states
//   is_access()     : true for states that drive a memory strobe
// -----------------------------------------------------------------------------
package image_dma_pkg;

  localparam int ADDR_W = 15;  // 2 banks x 16K words, addr[14] selects the bank
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    WR,
    DONE
  } dma_state_t;

  function automatic logic is_access(dma_state_t s);
    return (s == RD) || (s == WR);
  endfunction

endpackage

// File: rtl/image_dma_ctr.sv
// -----------------------------------------------------------------------------
// image_dma_ctr
// Loadable up-counter that wraps modulo 2^W. Used for the source address,
// destination address and completed-word count of the copy engine.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (has priority over inc_i)
//   load_val_i  : value loaded on load_i
//   inc_i       : increment by one, wrapping at 2^W
//   count_o     : current count
//   next_o      : value the count takes on the next clock edge
// -----------------------------------------------------------------------------
module image_dma_ctr #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o
);

  logic [W-1:0] count_q, count_d;

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/image_dma.sv
// -----------------------------------------------------------------------------
// image_dma
// Block-copy engine for the 32K x 16 two-bank image memory. Copies `length`
// words from src_addr to dst_addr as RD -> WT -> WR per word; addresses wrap
// modulo 2^ADDR_W, so copies may cross banks freely.
// Optional feature macro: IMAGE_DMA_FILL_EN -- when defined, a start with
// fill_mode=1 writes fill_value to every destination word, one word per cycle,
// with no reads. Without the macro fill_mode/fill_value are ignored.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle request, sampled only in IDLE
//   src_addr, dst_addr    first source / destination word address (latched)
//   length                words to move (latched), 0 = no transfer
//   abort                 stop in any non-IDLE state, no done pulse
//   fill_mode, fill_value fill request and fill word (latched)
//   mem_enable, mem_write_enable, mem_read_enable, mem_address,
//   mem_input_data        registered memory request outputs
//   mem_output_data       memory read data, valid MEM_RD_LAT cycles after RD
//   busy                  transfer in progress (RD/WT/WR)
//   done                  1-cycle completion pulse
//   words_done            writes completed in the current/last transfer
// MEM_RD_LAT (1..3) is the read latency; WT lasts MEM_RD_LAT cycles so one
// word takes 2+MEM_RD_LAT cycles. ADDR_W/DATA_W are fixed in image_dma_pkg.
// -----------------------------------------------------------------------------
module image_dma
  import image_dma_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  addr_t src_addr,
  input  addr_t dst_addr,
  input  addr_t length,
  input  logic  abort,
  input  logic  fill_mode,
  input  data_t fill_value,
  output logic  mem_enable,
  output logic  mem_write_enable,
  output logic  mem_read_enable,
  output addr_t mem_address,
  output data_t mem_input_data,
  input  data_t mem_output_data,
  output logic  busy,
  output logic  done,
  output addr_t words_done
);

  localparam logic [1:0] WT_LAST = 2'(MEM_RD_LAT - 1);

  dma_state_t state_q, state_d;
  logic [1:0] wt_cnt_q, wt_cnt_d;
  addr_t      len_q;
  data_t      data_q, data_d, wr_data_d;
  addr_t      src_q, src_d, dst_q, dst_d, words_q, words_d;
  addr_t      mem_addr_d;
  logic       accept, in_wr, fill_en_d;

  logic  mem_en_q, mem_we_q, mem_re_q, busy_q, done_q;
  addr_t mem_addr_q;
  data_t mem_wdata_q;

  assign accept = (state_q == IDLE) && start;
  assign in_wr  = (state_q == WR);

`ifdef IMAGE_DMA_FILL_EN
  logic  fill_mode_q;
  data_t fill_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_mode_q <= 1'b0;
      fill_val_q  <= '0;
    end else if (accept) begin
      fill_mode_q <= fill_mode;
      fill_val_q  <= fill_value;
    end
  end

  // Use the incoming operands on the accept edge so the first fill write is
  // issued straight out of IDLE.
  assign fill_en_d = accept ? fill_mode : fill_mode_q;
  assign wr_data_d = fill_en_d ? (accept ? fill_value : fill_val_q) : data_d;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_mode, fill_value};
  assign fill_en_d   = 1'b0;
  assign wr_data_d   = data_d;
`endif

  // Addresses advance once per issued write, including a write whose cycle
  // coincides with abort, so words_done counts every write the memory saw.
  image_dma_ctr #(.W(ADDR_W)) u_src_ctr (
    .clk, .rst_n, .load_i(accept), .load_val_i(src_addr), .inc_i(in_wr),
    .count_o(src_q), .next_o(src_d)
  );

  image_dma_ctr #(.W(ADDR_W)) u_dst_ctr (
    .clk, .rst_n, .load_i(accept), .load_val_i(dst_addr), .inc_i(in_wr),
    .count_o(dst_q), .next_o(dst_d)
  );

  image_dma_ctr #(.W(ADDR_W)) u_words_ctr (
    .clk, .rst_n, .load_i(accept), .load_val_i('0), .inc_i(in_wr),
    .count_o(words_q), .next_o(words_d)
  );

  // Only the next-value side of the address counters feeds the address register.
  logic unused_ctr;
  assign unused_ctr = ^{src_q, dst_q};

  always_comb begin
    state_d  = state_q;
    wt_cnt_d = wt_cnt_q;
    data_d   = data_q;
    case (state_q)
      IDLE: if (start) state_d = (length == '0) ? DONE : (fill_en_d ? WR : RD);
      RD: begin
        wt_cnt_d = '0;
        state_d  = WT;
      end
      WT: begin
        if (wt_cnt_q == WT_LAST) begin
          data_d  = mem_output_data;
          state_d = WR;
        end else begin
          wt_cnt_d = wt_cnt_q + 2'd1;
        end
      end
      WR:      state_d = (words_d == len_q) ? DONE : (fill_en_d ? WR : RD);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // start wins over abort in IDLE because abort is only honoured elsewhere.
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Outputs are registered from the next state, so they line up with the
  // state they belong to without a combinational path to the memory.
  always_comb begin
    mem_addr_d = '0;
    if (state_d == RD)      mem_addr_d = src_d;
    else if (state_d == WR) mem_addr_d = dst_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wt_cnt_q    <= '0;
      len_q       <= '0;
      data_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wt_cnt_q    <= wt_cnt_d;
      data_q      <= data_d;
      if (accept) len_q <= length;
      mem_en_q    <= is_access(state_d);
      mem_we_q    <= (state_d == WR);
      mem_re_q    <= (state_d == RD);
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= (state_d == WR) ? wr_data_d : '0;
      busy_q      <= state_d inside {RD, WT, WR};
      done_q      <= (state_d == DONE);
    end
  end

  assign mem_enable       = mem_en_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_address      = mem_addr_q;
  assign mem_input_data   = mem_wdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign words_done       = words_q;

endmodule

// File: tb/tb_image_dma.sv
// -----------------------------------------------------------------------------
// tb_image_dma
// Self-checking bench for image_dma with a 1-cycle-latency memory model.
// A transfer model predicts, from the start cycle and operands alone, which
// cycle carries which read/write, the busy window, the done cycle and the
// running word count; a compare process checks the DUT against it each cycle.
// Directed tests add literal expectations (latency, memory contents, address
// sequences) that pin the model itself.
// -----------------------------------------------------------------------------
module tb_image_dma;

  localparam int LAT = 1;
`ifdef IMAGE_DMA_FILL_EN
  localparam bit FILL_BUILD = 1'b1;
`else
  localparam bit FILL_BUILD = 1'b0;
`endif

  logic        clk, rst_n, start, abort, fill_mode;
  logic [14:0] src_addr, dst_addr, length, mem_address, words_done;
  logic [15:0] fill_value, mem_input_data, mem_output_data;
  logic        mem_enable, mem_write_enable, mem_read_enable, busy, done;

  image_dma #(.MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .abort(abort),
    .fill_mode(fill_mode), .fill_value(fill_value),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_address(mem_address),
    .mem_input_data(mem_input_data), .mem_output_data(mem_output_data),
    .busy(busy), .done(done), .words_done(words_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [15:0] mem [0:32767];
  logic [14:0] rd_log[$];
  logic [14:0] wr_log[$];

  // Transfer model state (written by the driver only).
  bit          m_active = 1'b0;
  bit          m_fill;
  int          m_start, m_len, m_stop;
  logic [14:0] m_src, m_dst, m_words_prev, m_words_last;
  logic [15:0] m_fv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    if (a >= 32'h4000 && a <= 32'h4003) return 16'hA001 + 16'(a - 32'h4000);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  // Word k is read in relative cycle p*k+1 and written in p*(k+1); done follows
  // the last write; abort in cycle a leaves outputs idle from a+1 onwards.
  task automatic model_eval(output logic re, output logic we, output logic bsy,
                            output logic dn, output logic [14:0] ad,
                            output logic [15:0] dt, output logic [14:0] wd);
    int rel, p, lim, r, k;
    bit stopped;
    re = 1'b0; we = 1'b0; bsy = 1'b0; dn = 1'b0; ad = '0; dt = '0;
    wd = m_words_last;
    if (m_active) begin
      rel = cyc - m_start;
      p   = m_fill ? 1 : 2 + LAT;
      lim = m_len * p;
      if (rel < 1) begin
        wd = m_words_prev;
      end else begin
        stopped = (m_stop >= 0) && (rel > m_stop);
        r = stopped ? m_stop + 1 : rel;
        if (r > lim + 1) r = lim + 1;
        wd = 15'((r - 1) / p);
        if (!stopped) begin
          if (rel <= lim) begin
            bsy = 1'b1;
            k = (rel - 1) / p;
            if (rel % p == 0) begin
              we = 1'b1;
              ad = 15'(int'(m_dst) + k);
              dt = m_fill ? m_fv : mem[15'(int'(m_src) + k)];
            end else if ((rel - 1) % p == 0) begin
              re = 1'b1;
              ad = 15'(int'(m_src) + k);
            end
          end else if (rel == lim + 1) begin
            dn = 1'b1;
          end
        end
      end
    end
  endtask

  // Memory model and cycle counter: writes land at the edge, read data is
  // presented one cycle after the read strobe.
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
    mem_output_data = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst_n && mem_enable && mem_write_enable) mem[mem_address] = mem_input_data;
      if (rst_n && mem_enable && mem_read_enable) mem_output_data <= mem[mem_address];
    end
  end

  // Per-cycle comparison against the model, plus bus logging.
  logic        e_re, e_we, e_bsy, e_dn;
  logic [14:0] e_ad, e_wd;
  logic [15:0] e_dt;
  initial begin
    forever begin
      @(negedge clk);
      model_eval(e_re, e_we, e_bsy, e_dn, e_ad, e_dt, e_wd);
      check("cyc_rd_en", 32'(mem_read_enable), 32'(e_re));
      check("cyc_wr_en", 32'(mem_write_enable), 32'(e_we));
      check("cyc_mem_en", 32'(mem_enable), 32'(e_re | e_we));
      check("cyc_busy", 32'(busy), 32'(e_bsy));
      check("cyc_done", 32'(done), 32'(e_dn));
      check("cyc_words", 32'(words_done), 32'(e_wd));
      if (e_re || e_we) check("cyc_addr", 32'(mem_address), 32'(e_ad));
      if (e_we) check("cyc_wdata", 32'(mem_input_data), 32'(e_dt));
      if (mem_read_enable) rd_log.push_back(mem_address);
      if (mem_write_enable) wr_log.push_back(mem_address);
      if (done) done_cnt++;
    end
  end

  task automatic do_start(input logic [14:0] s_a, input logic [14:0] d_a,
                          input logic [14:0] len, input bit fm,
                          input logic [15:0] fv, output int s_cyc);
    logic r0, w0, b0, d0;
    logic [14:0] a0, wd0;
    logic [15:0] t0;
    @(posedge clk);
    #1;
    rd_log.delete();
    wr_log.delete();
    src_addr = s_a; dst_addr = d_a; length = len; fill_mode = fm; fill_value = fv;
    start = 1'b1;
    s_cyc = cyc;
    model_eval(r0, w0, b0, d0, a0, t0, wd0);
    m_words_prev = wd0;
    m_src = s_a; m_dst = d_a; m_len = int'(len); m_fill = fm & FILL_BUILD;
    m_fv = fv; m_start = s_cyc; m_stop = -1; m_active = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; length = '0; fill_mode = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [14:0] exp_rd [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
  logic [14:0] exp_wr [4] = '{15'h3FFE, 15'h3FFF, 15'h4000, 15'h4001};

  initial begin
    int  s, dc, dcnt0;
    bit  seen;
    start = 1'b0; abort = 1'b0; fill_mode = 1'b0; fill_value = '0;
    src_addr = '0; dst_addr = '0; length = '0;
    m_start = 0; m_len = 0; m_stop = -1; m_fill = 1'b0;
    m_src = '0; m_dst = '0; m_fv = '0; m_words_prev = '0; m_words_last = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", 32'(mem_enable), 32'd0);
    check("rst_rd_wr", 32'({mem_read_enable, mem_write_enable}), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_words", 32'(words_done), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Bank1 -> bank0 copy of 4 words.
    do_start(15'h4000, 15'h0000, 15'd4, 1'b0, 16'h0, s);
    wait_done(100, dc);
    check("copy_latency", 32'(dc - s), 32'd13);
    check("copy_words", 32'(words_done), 32'd4);
    check("copy_nrd", 32'(rd_log.size()), 32'd4);
    check("copy_nwr", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("copy_data", 32'(mem[i]), 32'(16'hA001 + 16'(i)));

    // Zero-length start.
    do_start(15'h1111, 15'h2222, 15'd0, 1'b0, 16'h0, s);
    wait_done(20, dc);
    check("len0_latency", 32'(dc - s), 32'd1);
    check("len0_words", 32'(words_done), 32'd0);
    check("len0_strobes", 32'(rd_log.size() + wr_log.size()), 32'd0);

    // Address wrap across the top of memory.
    do_start(15'h7FFE, 15'h3FFE, 15'd4, 1'b0, 16'h0, s);
    wait_done(100, dc);
    check("wrap_nrd", 32'(rd_log.size()), 32'd4);
    check("wrap_nwr", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) check("wrap_rd_addr", 32'(rd_log[i]), 32'(exp_rd[i]));
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("wrap_wr_addr", 32'(wr_log[i]), 32'(exp_wr[i]));
    check("wrap_data_lo", 32'(mem[15'h4000]), 32'h0000A001);

    // Abort in the second WT (relative cycle 5) of an 8-word copy.
    dcnt0 = done_cnt;
    do_start(15'h4000, 15'h0100, 15'd8, 1'b0, 16'h0, s);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    m_stop = cyc - m_start;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_nwr", 32'(wr_log.size()), 32'd1);
    check("abort_words", 32'(words_done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done_cnt - dcnt0), 32'd0);

    // start while busy with different operands is dropped.
    do_start(15'h4000, 15'h0200, 15'd4, 1'b0, 16'h0, s);
    repeat (2) @(posedge clk);
    #1;
    src_addr = 15'h1234; dst_addr = 15'h2000; length = 15'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; length = '0;
    wait_done(100, dc);
    check("busy_start_latency", 32'(dc - s), 32'd13);
    check("busy_start_words", 32'(words_done), 32'd4);
    check("busy_start_dst2", 32'(mem[15'h2000]), 32'(init_val(32'h2000)));
    for (int i = 0; i < 4; i++) check("busy_start_data", 32'(mem[15'h0200 + 15'(i)]), 32'(16'hA001 + 16'(i)));

    // Fill request (copy when the feature is compiled out).
    do_start(15'h4000, 15'h0010, 15'd3, 1'b1, 16'h00FF, s);
    wait_done(100, dc);
    check("fill_nwr", 32'(wr_log.size()), 32'd3);
`ifdef IMAGE_DMA_FILL_EN
    check("fill_nrd", 32'(rd_log.size()), 32'd0);
    check("fill_latency", 32'(dc - s), 32'd4);
    for (int i = 0; i < 3; i++) check("fill_data", 32'(mem[15'h0010 + 15'(i)]), 32'h000000FF);
`else
    check("fill_off_nrd", 32'(rd_log.size()), 32'd3);
    check("fill_off_latency", 32'(dc - s), 32'd10);
    for (int i = 0; i < 3; i++) check("fill_off_data", 32'(mem[15'h0010 + 15'(i)]), 32'(16'hA001 + 16'(i)));
`endif

    // Reset asserted during a WR cycle, then a fresh copy.
    do_start(15'h4000, 15'h0300, 15'd4, 1'b0, 16'h0, s);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_write_enable) seen = 1'b1;
    end
    check("rst_mid_wr_seen", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    m_active = 1'b0;
    m_words_last = '0;
    #1;
    check("rst_mid_strobes", 32'({mem_enable, mem_read_enable, mem_write_enable}), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_words", 32'(words_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(15'h4000, 15'h0400, 15'd2, 1'b0, 16'h0, s);
    wait_done(100, dc);
    check("post_rst_latency", 32'(dc - s), 32'd7);
    check("post_rst_d0", 32'(mem[15'h0400]), 32'h0000A001);
    check("post_rst_d1", 32'(mem[15'h0401]), 32'h0000A002);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
